uart_fifo_wb: RTL



---
 rtl/uart_pkg.sv | 48 ++++
 rtl/uart_sync_fifo.sv | 57 +++++
 rtl/uart_fifo_wb.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the uart_fifo_wb slave.
//   - tx/rx FSM state enums (parity state present only with UART_PARITY_EN)
//   - status byte bit indices (within wb_dat_o[23:16]) and control bit indices
//   - word address constants for wb_adr_i
package uart_pkg;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
`ifdef UART_PARITY_EN
    TX_PARITY,
`endif
    TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
`ifdef UART_PARITY_EN
    RX_PARITY,
`endif
    RX_STOP
  } rx_state_t;

  // word addresses (wb_adr_i is address bit 2)
  localparam logic ADR_DATA = 1'b0;
  localparam logic ADR_CTRL = 1'b1;

  // byte lane carrying data and control fields
  localparam int SEL_LANE = 3;

  // status byte bit positions
  localparam int ST_RX_OVERRUN = 7;
  localparam int ST_TX_IDLE    = 6;
  localparam int ST_TX_EMPTY   = 5;
  localparam int ST_TX_FULL    = 4;
  localparam int ST_PARITY_ERR = 3;
  localparam int ST_FRAME_ERR  = 2;
  localparam int ST_RX_AVAIL   = 0;

  // control word bit positions
  localparam int CTL_RX_IE = 24;
  localparam int CTL_TX_IE = 25;
  localparam int CTL_CLR   = 31;

endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: single-clock FIFO, DEPTH entries (power of two) of WIDTH bits.
// Ports:
//   clk_i, rst_i     clock, synchronous active-low reset
//   push, wdata      write strobe / data (dropped when full, even with a pop)
//   pop              read strobe (ignored when empty)
//   rdata            head entry (combinational, valid when not empty)
//   empty, full      occupancy flags
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/uart_fifo_wb.sv
// uart_fifo_wb: Wishbone two-word UART slave with DEPTH-entry TX and RX FIFOs.
// Optional feature macro: UART_PARITY_EN (even parity bit after the data bits).
// Ports:
//   clk_i, rst_i               clock, synchronous active-low reset
//   wb_cyc_i/stb_i/we_i        Wishbone controls; wb_adr_i: 0 data/status, 1 control
//   wb_sel_i, wb_dat_i         byte selects / write data (lane 3 carries the fields)
//   wb_dat_o, wb_ack_o         registered read data / one-cycle acknowledge
//   wb_err_o, wb_rty_o         tied 0
//   int_o                      registered interrupt
//   srx_pad_i, stx_pad_o       serial in (asynchronous) / serial out
module uart_fifo_wb
  import uart_pkg::*;
#(
  parameter int CLK_DIV   = 347,
  parameter int DEPTH     = 16,
  parameter int DATA_BITS = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic        wb_adr_i,
  input  logic [3:0]  wb_sel_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        wb_err_o,
  output logic        wb_rty_o,
  output logic        int_o,
  input  logic        srx_pad_i,
  output logic        stx_pad_o
);

  localparam int CW = $clog2(CLK_DIV);

  // ---------------- bus decode ----------------
  logic take, lane, wr_data, wr_ctrl, rd_data_pop, clr;
  logic tx_push, tx_pop, tx_empty, tx_full;
  logic rx_push, rx_pop, rx_empty, rx_full;
  logic [DATA_BITS-1:0] tx_head, rx_head, rx_wdata;
  logic rx_ie, tx_ie, rx_overrun, frame_err, parity_bit;
  logic set_ovr, set_ferr, set_perr;
  logic [7:0]  status, rx_byte;
  logic [31:0] ctrl_word;
  logic unused_bus;

  assign unused_bus  = ^{wb_dat_i, wb_sel_i};
  assign take        = wb_cyc_i & wb_stb_i & ~wb_ack_o;
  assign lane        = wb_sel_i[SEL_LANE];
  assign wr_data     = take & wb_we_i & (wb_adr_i == ADR_DATA) & lane;
  assign wr_ctrl     = take & wb_we_i & (wb_adr_i == ADR_CTRL) & lane;
  assign rd_data_pop = take & ~wb_we_i & (wb_adr_i == ADR_DATA) & lane;
  assign clr         = wr_ctrl & wb_dat_i[CTL_CLR];
  assign tx_push     = wr_data;
  assign rx_pop      = rd_data_pop & ~rx_empty;
  assign wb_err_o    = 1'b0;
  assign wb_rty_o    = 1'b0;

  uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(DEPTH)) u_tx_fifo (
    .clk_i(clk_i), .rst_i(rst_i), .push(tx_push), .wdata(wb_dat_i[24 +: DATA_BITS]),
    .pop(tx_pop), .rdata(tx_head), .empty(tx_empty), .full(tx_full)
  );

  uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(DEPTH)) u_rx_fifo (
    .clk_i(clk_i), .rst_i(rst_i), .push(rx_push), .wdata(rx_wdata),
    .pop(rx_pop), .rdata(rx_head), .empty(rx_empty), .full(rx_full)
  );

  // ---------------- transmitter ----------------
  tx_state_t            tx_state, tx_state_d;
  logic [CW-1:0]        tx_cnt, tx_cnt_d;
  logic [3:0]           tx_bit, tx_bit_d;
  logic [DATA_BITS-1:0] tx_shift, tx_shift_d;
  logic                 tx_tick, tx_line_d;
`ifdef UART_PARITY_EN
  logic                 tx_par, tx_par_d;
`endif

  assign tx_tick = (tx_cnt == CW'(CLK_DIV - 1));

  always_comb begin
    tx_state_d = tx_state;
    tx_cnt_d   = (tx_state == TX_IDLE) ? tx_cnt : (tx_tick ? '0 : tx_cnt + 1'b1);
    tx_bit_d   = tx_bit;
    tx_shift_d = tx_shift;
    tx_pop     = 1'b0;
`ifdef UART_PARITY_EN
    tx_par_d   = tx_par;
`endif
    case (tx_state)
      TX_IDLE: if (!tx_empty) begin
        tx_pop     = 1'b1;
        tx_state_d = TX_START;
        tx_shift_d = tx_head;
        tx_cnt_d   = '0;
`ifdef UART_PARITY_EN
        tx_par_d   = ^tx_head;
`endif
      end
      TX_START: if (tx_tick) begin
        tx_state_d = TX_DATA;
        tx_bit_d   = '0;
      end
      TX_DATA: if (tx_tick) begin
        tx_shift_d = tx_shift >> 1;
        if (tx_bit == 4'(DATA_BITS - 1))
`ifdef UART_PARITY_EN
          tx_state_d = TX_PARITY;
`else
          tx_state_d = TX_STOP;
`endif
        else
          tx_bit_d = tx_bit + 4'd1;
      end
`ifdef UART_PARITY_EN
      TX_PARITY: if (tx_tick) tx_state_d = TX_STOP;
`endif
      TX_STOP: if (tx_tick) begin
        if (!tx_empty) begin
          tx_pop     = 1'b1;
          tx_state_d = TX_START;
          tx_shift_d = tx_head;
`ifdef UART_PARITY_EN
          tx_par_d   = ^tx_head;
`endif
        end else begin
          tx_state_d = TX_IDLE;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase

    // line is registered from the next state so the pad changes with the state
    case (tx_state_d)
      TX_START:  tx_line_d = 1'b0;
      TX_DATA:   tx_line_d = tx_shift_d[0];
`ifdef UART_PARITY_EN
      TX_PARITY: tx_line_d = tx_par_d;
`endif
      default:   tx_line_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      tx_state  <= TX_IDLE;
      tx_cnt    <= '0;
      tx_bit    <= '0;
      tx_shift  <= '0;
      stx_pad_o <= 1'b1;
`ifdef UART_PARITY_EN
      tx_par    <= 1'b0;
`endif
    end else begin
      tx_state  <= tx_state_d;
      tx_cnt    <= tx_cnt_d;
      tx_bit    <= tx_bit_d;
      tx_shift  <= tx_shift_d;
      stx_pad_o <= tx_line_d;
`ifdef UART_PARITY_EN
      tx_par    <= tx_par_d;
`endif
    end
  end

  // ---------------- receiver ----------------
  rx_state_t            rx_state, rx_state_d;
  logic [CW-1:0]        rx_cnt, rx_cnt_d;
  logic [3:0]           rx_bit, rx_bit_d;
  logic [DATA_BITS-1:0] rx_shift, rx_shift_d;
  logic                 rx_s1, rx_s2, rx_prev, rx_tick, rx_half;
`ifdef UART_PARITY_EN
  logic                 rx_perr, rx_perr_d;
`endif

  assign rx_tick  = (rx_cnt == CW'(CLK_DIV - 1));
  assign rx_half  = (rx_cnt == CW'(CLK_DIV / 2 - 1));
  assign rx_wdata = rx_shift;

  always_comb begin
    rx_state_d = rx_state;
    rx_cnt_d   = rx_cnt + 1'b1;
    rx_bit_d   = rx_bit;
    rx_shift_d = rx_shift;
    rx_push    = 1'b0;
    set_ovr    = 1'b0;
    set_ferr   = 1'b0;
    set_perr   = 1'b0;
`ifdef UART_PARITY_EN
    rx_perr_d  = rx_perr;
`endif
    case (rx_state)
      RX_IDLE: begin
        rx_cnt_d = '0;
        if (rx_prev & ~rx_s2) rx_state_d = RX_START;
      end
      RX_START: if (rx_half) begin
        rx_cnt_d   = '0;
        rx_bit_d   = '0;
        rx_state_d = rx_s2 ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (rx_tick) begin
        rx_cnt_d   = '0;
        rx_shift_d = {rx_s2, rx_shift[DATA_BITS-1:1]};
        if (rx_bit == 4'(DATA_BITS - 1))
`ifdef UART_PARITY_EN
          rx_state_d = RX_PARITY;
`else
          rx_state_d = RX_STOP;
`endif
        else
          rx_bit_d = rx_bit + 4'd1;
      end
`ifdef UART_PARITY_EN
      RX_PARITY: if (rx_tick) begin
        rx_cnt_d   = '0;
        rx_perr_d  = rx_s2 ^ (^rx_shift);
        rx_state_d = RX_STOP;
      end
`endif
      RX_STOP: if (rx_tick) begin
        rx_cnt_d   = '0;
        rx_state_d = RX_IDLE;
        if (!rx_s2)       set_ferr = 1'b1;
        else if (rx_full) set_ovr  = 1'b1;
        else begin
          rx_push = 1'b1;
`ifdef UART_PARITY_EN
          set_perr = rx_perr;
`endif
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_prev  <= 1'b1;
`ifdef UART_PARITY_EN
      rx_perr  <= 1'b0;
`endif
    end else begin
      rx_state <= rx_state_d;
      rx_cnt   <= rx_cnt_d;
      rx_bit   <= rx_bit_d;
      rx_shift <= rx_shift_d;
      rx_s1    <= srx_pad_i;
      rx_s2    <= rx_s1;
      rx_prev  <= rx_s2;
`ifdef UART_PARITY_EN
      rx_perr  <= rx_perr_d;
`endif
    end
  end

  // ---------------- registers, status, interrupt ----------------
`ifdef UART_PARITY_EN
  logic parity_err;
  assign parity_bit = parity_err;
`else
  assign parity_bit = 1'b0;
`endif

  always_comb begin
    status                = '0;
    status[ST_RX_OVERRUN] = rx_overrun;
    status[ST_TX_IDLE]    = tx_empty & (tx_state == TX_IDLE);
    status[ST_TX_EMPTY]   = tx_empty;
    status[ST_TX_FULL]    = tx_full;
    status[ST_PARITY_ERR] = parity_bit;
    status[ST_FRAME_ERR]  = frame_err;
    status[ST_RX_AVAIL]   = ~rx_empty;
    rx_byte               = rx_empty ? 8'h00 : 8'(rx_head);
    ctrl_word             = '0;
    ctrl_word[CTL_RX_IE]  = rx_ie;
    ctrl_word[CTL_TX_IE]  = tx_ie;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      wb_ack_o   <= 1'b0;
      wb_dat_o   <= '0;
      int_o      <= 1'b0;
      rx_ie      <= 1'b0;
      tx_ie      <= 1'b0;
      rx_overrun <= 1'b0;
      frame_err  <= 1'b0;
`ifdef UART_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else begin
      wb_ack_o <= take;
      if (take & ~wb_we_i)
        wb_dat_o <= (wb_adr_i == ADR_DATA) ? {rx_byte, status, 16'h0000} : ctrl_word;
      if (wr_ctrl) begin
        rx_ie <= wb_dat_i[CTL_RX_IE];
        tx_ie <= wb_dat_i[CTL_TX_IE];
      end
      // a flag raised in the same cycle as a clear survives it
      rx_overrun <= set_ovr  | (rx_overrun & ~clr);
      frame_err  <= set_ferr | (frame_err  & ~clr);
`ifdef UART_PARITY_EN
      parity_err <= set_perr | (parity_err & ~clr);
`endif
      int_o <= (rx_ie & ~rx_empty) | (tx_ie & tx_empty);
    end
  end

  logic unused_perr;
  assign unused_perr = set_perr;

endmodule
